ddr_ring_slot_mgr: RTL and testbench
====================================

# ddr_ring_slot_mgr

Multi-channel slot manager for DDR-backed ring buffers. It keeps per-channel write/read slot pointers and occupancy counters, generates burst base addresses, and arbitrates drain (read) commands round-robin across channels. Watermark events are stretched into sticky, clearable interrupts. It sits between the stream staging FIFOs/write engine and the AXI read engine, and replaces the single-channel pointer logic with N independent rings.

## Interface
- NUM_CHANNELS, 4, number of independent rings (1..16)
- AXI_ADDR_WIDTH, 32, DDR address width
- AXI_DATA_WIDTH, 64, DDR data width; power of two
- DRAIN_BURST_LEN, 128, beats per slot; power of two; BURST_BYTES = DRAIN_BURST_LEN*AXI_DATA_WIDTH/8
- SLOT_CNT_WIDTH, 16, width of slot indices and counters; CW = $clog2(NUM_CHANNELS), min 1
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  asynchronous, active-high reset
- CFG_BASE_ADDR  in  NUM_CHANNELS*AXI_ADDR_WIDTH  per-channel ring base, BURST_BYTES-aligned
- CFG_RING_LEN  in  NUM_CHANNELS*SLOT_CNT_WIDTH  slots per ring; 0 = channel disabled
- CFG_WATERMARK  in  NUM_CHANNELS*SLOT_CNT_WIDTH  fill level raising WM_IRQ
- SOFT_CLEAR  in  NUM_CHANNELS  per-channel synchronous pointer/counter clear
- WR_REQ_VALID / WR_REQ_READY  in / out  1  slot allocation handshake
- WR_REQ_CH  in  CW  channel requesting a slot
- WR_REQ_ADDR  out  AXI_ADDR_WIDTH  address of allocated slot, valid with WR_REQ_READY
- WR_DONE_VALID  in  1  write burst of WR_DONE_CH completed (BRESP seen)
- WR_DONE_CH  in  CW
- RD_CMD_VALID / RD_CMD_READY  out / in  1  drain command handshake
- RD_CMD_CH  out  CW;  RD_CMD_ADDR  out  AXI_ADDR_WIDTH
- RD_DONE_VALID  in  1  drained slot of RD_DONE_CH consumed, slot freed
- RD_DONE_CH  in  CW
- FILL  out  NUM_CHANNELS*SLOT_CNT_WIDTH  committed, not-yet-freed slots
- FULL, EMPTY  out  NUM_CHANNELS each
- WM_IRQ  out  NUM_CHANNELS  sticky watermark interrupt
- WM_CLEAR  in  NUM_CHANNELS  clears WM_IRQ bit
- PROTO_ERR  out  1  sticky; DONE without matching outstanding operation

## Operation
- Per channel state: wptr, rptr (slot indices), used (allocated, not freed), fill (committed, not freed), avail (committed, not yet issued), wr_pend, rd_pend.
- Slot address = base + idx*BURST_BYTES (shift, not multiply); index wraps ring_len-1 -> 0.
- WR_REQ_READY = enabled(ch) & (used < ring_len), combinational from registered state; WR_REQ_ADDR = address(wptr[ch]). On handshake: wptr advance, used+1, wr_pend+1.
- WR_DONE: wr_pend-1, fill+1, avail+1. Completions are in order per channel.
- Arbiter: when RD_CMD register is empty or being accepted this cycle, pick the first channel with avail>0 searching round-robin from last granted+1; load CH/ADDR, rptr advance, avail-1, rd_pend+1 at that edge.
- RD_CMD_* held stable while VALID & !READY.
- RD_DONE: rd_pend-1, fill-1, used-1.
- All same-cycle events on one channel combine by net arithmetic (e.g. alloc+free leaves used unchanged).
- WR_DONE with wr_pend==0 or RD_DONE with rd_pend==0: ignored, PROTO_ERR set (cleared only by reset).
- FULL = used==ring_len & enabled; EMPTY = fill==0.
- WM_IRQ: set on rising edge of (fill >= watermark & watermark!=0); WM_CLEAR wins over simultaneous set; no re-set until condition falls and rises again.
- SOFT_CLEAR[ch]: zero all state of ch at next edge; clear wins over any same-cycle event on ch. A pending RD_CMD of ch stays valid until accepted. Software quiesces the channel first; stray DONEs raise PROTO_ERR.
- Disabled channel: never ready, never arbitrated.

## Timing
- Reset: all counters/pointers 0, RD_CMD_VALID 0, round-robin start at channel 0, WM_IRQ 0, PROTO_ERR 0.
- WR_DONE sampled at edge t -> RD_CMD_VALID high from edge t+1 if register free.
- Back-to-back RD_CMD accepts: one command per cycle.
- FILL/FULL/EMPTY/WM_IRQ registered, updated at the edge that samples the event.

## Structure
- Package ddr_ring_pkg: chan_state_t struct, BURST_BYTES/BURST_SHIFT localparams, slot_addr() function.
- Sub-module rr_arbiter (NUM_CHANNELS request vector, last-grant pointer, one-hot/index grant).

## Test plan
- Ch0 ring_len=4, base 0x1000_0000, BURST_BYTES=1024: 4 allocs -> addrs 0x1000_0000..0x1000_0C00, FULL[0]=1, 5th WR_REQ_READY=0; a 5th alloc after one RD_DONE -> 0x1000_0000 (wrap).
- Commits on ch1,ch2,ch3 in one cycle each, RD_CMD_READY=1 -> RD_CMD_CH order 1,2,3; RD_CMD_VALID 1 cycle after first commit.
- RD_CMD_READY held 0 for 5 cycles -> CH/ADDR stable, no avail change.
- Watermark=3: fill 2->3 sets WM_IRQ; WM_CLEAR while fill stays 3 -> stays 0; fill 2->3 again sets it.
- RD_DONE on idle ch2 -> PROTO_ERR=1, FILL unchanged; SOFT_CLEAR with simultaneous WR_DONE -> all ch state 0.
- Assert S_AXI_ARESET mid-burst -> all outputs reset immediately, RD_CMD_VALID=0.

Source files
------------

// File: rtl/ddr_ring_pkg.sv
// ddr_ring_pkg: shared types, burst geometry defaults and slot address helpers
package ddr_ring_pkg;
  localparam int CNT_W = 16;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_BURST_LEN = 128;
  localparam int BURST_BYTES = DEF_BURST_LEN * DEF_DATA_W / 8;
  localparam int BURST_SHIFT = $clog2(BURST_BYTES);
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    cnt_t wptr;
    cnt_t rptr;
    cnt_t used;
    cnt_t fill;
    cnt_t avail;
    cnt_t wr_pend;
    cnt_t rd_pend;
  } chan_state_t;
  function automatic logic [63:0] slot_addr(input logic [63:0] base, input cnt_t idx, input int shift = BURST_SHIFT);
    return base + (64'(idx) << shift);
  endfunction
  function automatic cnt_t next_idx(input cnt_t idx, input cnt_t len);
    return (idx == len - 1'b1) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester after the last grant
module rr_arbiter #(
  parameter int N = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic [N-1:0]  gnt_oh,
  output logic [CW-1:0] gnt_idx,
  output logic          any
);
  // scan downward so the nearest requester after last overwrites farther ones
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    for (int i = N; i >= 1; i--)
      if (req[(int'(last) + i) % N]) begin
        gnt_idx = CW'((int'(last) + i) % N);
        any = 1'b1;
      end
    gnt_oh = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/ddr_ring_slot_mgr.sv
// ddr_ring_slot_mgr: per-channel DDR ring pointers, occupancy and round-robin drain issue
module ddr_ring_slot_mgr
  import ddr_ring_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DRAIN_BURST_LEN = 128,
  parameter int SLOT_CNT_WIDTH = CNT_W,
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  input  logic [NUM_CHANNELS*AXI_ADDR_WIDTH-1:0]   CFG_BASE_ADDR,
  input  logic [NUM_CHANNELS*SLOT_CNT_WIDTH-1:0]   CFG_RING_LEN,
  input  logic [NUM_CHANNELS*SLOT_CNT_WIDTH-1:0]   CFG_WATERMARK,
  input  logic [NUM_CHANNELS-1:0]                  SOFT_CLEAR,
  input  logic                                     WR_REQ_VALID,
  output logic                                     WR_REQ_READY,
  input  logic [CW-1:0]                            WR_REQ_CH,
  output logic [AXI_ADDR_WIDTH-1:0]                WR_REQ_ADDR,
  input  logic                                     WR_DONE_VALID,
  input  logic [CW-1:0]                            WR_DONE_CH,
  output logic                                     RD_CMD_VALID,
  input  logic                                     RD_CMD_READY,
  output logic [CW-1:0]                            RD_CMD_CH,
  output logic [AXI_ADDR_WIDTH-1:0]                RD_CMD_ADDR,
  input  logic                                     RD_DONE_VALID,
  input  logic [CW-1:0]                            RD_DONE_CH,
  output logic [NUM_CHANNELS*SLOT_CNT_WIDTH-1:0]   FILL,
  output logic [NUM_CHANNELS-1:0]                  FULL,
  output logic [NUM_CHANNELS-1:0]                  EMPTY,
  output logic [NUM_CHANNELS-1:0]                  WM_IRQ,
  input  logic [NUM_CHANNELS-1:0]                  WM_CLEAR,
  output logic                                     PROTO_ERR
);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int SW = SLOT_CNT_WIDTH;
  localparam int SHIFT = $clog2(DRAIN_BURST_LEN * AXI_DATA_WIDTH / 8);
  chan_state_t st [NUM_CHANNELS];
  chan_state_t nx [NUM_CHANNELS];
  cnt_t len [NUM_CHANNELS];
  cnt_t wm [NUM_CHANNELS];
  logic [AW-1:0] base [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] en, req, gnt_oh, alloc, wd, rdn, iss, wm_cond, wm_cond_q, wm_irq_q;
  logic [CW-1:0] gnt_idx, last, rd_ch;
  logic [AW-1:0] rd_addr, cmd_addr;
  logic any, load, err, rd_valid, proto;
  assign load = !rd_valid | RD_CMD_READY;
  assign cmd_addr = AW'(slot_addr(64'(base[gnt_idx]), st[gnt_idx].rptr, SHIFT));
  // unpack configuration; channels being cleared do not compete for the drain slot
  always_comb begin
    en = '0;
    req = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      len[c] = cnt_t'(CFG_RING_LEN[c*SW +: SW]);
      wm[c] = cnt_t'(CFG_WATERMARK[c*SW +: SW]);
      base[c] = CFG_BASE_ADDR[c*AW +: AW];
      en[c] = len[c] != '0;
      req[c] = en[c] & (st[c].avail != '0) & ~SOFT_CLEAR[c];
    end
  end
  rr_arbiter #(.N(NUM_CHANNELS), .CW(CW)) u_arb (
    .req(req), .last(last), .gnt_oh(gnt_oh), .gnt_idx(gnt_idx), .any(any)
  );
  // write-side handshake and status flags from registered state
  always_comb begin
    WR_REQ_READY = 1'b0;
    WR_REQ_ADDR = '0;
    FILL = '0;
    FULL = '0;
    EMPTY = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (int'(WR_REQ_CH) == c) begin
        WR_REQ_READY = en[c] & (st[c].used < len[c]);
        WR_REQ_ADDR = AW'(slot_addr(64'(base[c]), st[c].wptr, SHIFT));
      end
      FILL[c*SW +: SW] = SW'(st[c].fill);
      FULL[c] = en[c] & (st[c].used == len[c]);
      EMPTY[c] = st[c].fill == '0;
    end
  end
  // net per-channel update of all same-cycle events; stray DONEs are dropped and flagged
  always_comb begin
    alloc = '0;
    wd = '0;
    rdn = '0;
    iss = '0;
    wm_cond = '0;
    err = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      nx[c] = st[c];
      alloc[c] = WR_REQ_VALID & WR_REQ_READY & (int'(WR_REQ_CH) == c);
      wd[c] = WR_DONE_VALID & (int'(WR_DONE_CH) == c) & (st[c].wr_pend != '0);
      rdn[c] = RD_DONE_VALID & (int'(RD_DONE_CH) == c) & (st[c].rd_pend != '0);
      iss[c] = load & gnt_oh[c];
      err = err | (WR_DONE_VALID & (int'(WR_DONE_CH) == c) & (st[c].wr_pend == '0))
                | (RD_DONE_VALID & (int'(RD_DONE_CH) == c) & (st[c].rd_pend == '0));
      nx[c].wptr = alloc[c] ? next_idx(st[c].wptr, len[c]) : st[c].wptr;
      nx[c].rptr = iss[c] ? next_idx(st[c].rptr, len[c]) : st[c].rptr;
      nx[c].used = st[c].used + cnt_t'(alloc[c]) - cnt_t'(rdn[c]);
      nx[c].wr_pend = st[c].wr_pend + cnt_t'(alloc[c]) - cnt_t'(wd[c]);
      nx[c].fill = st[c].fill + cnt_t'(wd[c]) - cnt_t'(rdn[c]);
      nx[c].avail = st[c].avail + cnt_t'(wd[c]) - cnt_t'(iss[c]);
      nx[c].rd_pend = st[c].rd_pend + cnt_t'(iss[c]) - cnt_t'(rdn[c]);
      if (SOFT_CLEAR[c]) nx[c] = '0;
      wm_cond[c] = (wm[c] != '0) & (nx[c].fill >= wm[c]);
    end
  end
  // channel state, edge-triggered sticky watermark interrupts and sticky protocol error
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int c = 0; c < NUM_CHANNELS; c++) st[c] <= '0;
      wm_cond_q <= '0;
      wm_irq_q <= '0;
      proto <= 1'b0;
    end else begin
      st <= nx;
      wm_cond_q <= wm_cond;
      wm_irq_q <= ~WM_CLEAR & (wm_irq_q | (wm_cond & ~wm_cond_q));
      proto <= proto | err;
    end
  end
  // drain command register; last starts at the top channel so the first search begins at 0
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rd_valid <= 1'b0;
      rd_ch <= '0;
      rd_addr <= '0;
      last <= CW'(NUM_CHANNELS - 1);
    end else if (load) begin
      rd_valid <= any;
      if (any) begin
        rd_ch <= gnt_idx;
        rd_addr <= cmd_addr;
        last <= gnt_idx;
      end
    end
  end
  assign RD_CMD_VALID = rd_valid;
  assign RD_CMD_CH = rd_ch;
  assign RD_CMD_ADDR = rd_addr;
  assign WM_IRQ = wm_irq_q;
  assign PROTO_ERR = proto;
endmodule

// File: tb/tb_ddr_ring_slot_mgr.sv
// tb_ddr_ring_slot_mgr: directed table and sequence checks for the ring slot manager
module tb_ddr_ring_slot_mgr;
  logic clk = 1'b0;
  logic rst;
  logic [127:0] base;
  logic [63:0] ring, wmk, fill;
  logic [3:0] sclr, wmclr, full, empty, irq;
  logic wr_v, wr_rdy, wd_v, rd_v, rd_rdy, rdn_v, perr;
  logic [1:0] wr_ch, wd_ch, rd_ch, rdn_ch;
  logic [31:0] wr_addr, rd_addr;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic wv;
    logic dv;
    logic rv;
    logic rdy;
    logic exp_rdy;
    logic [31:0] exp_addr;
    logic [15:0] exp_fill;
    logic exp_full;
    logic exp_valid;
    logic [31:0] exp_cmd;
  } vec_t;
  vec_t tv [9];

  always #5 clk = ~clk;

  ddr_ring_slot_mgr dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .CFG_BASE_ADDR(base), .CFG_RING_LEN(ring), .CFG_WATERMARK(wmk), .SOFT_CLEAR(sclr),
    .WR_REQ_VALID(wr_v), .WR_REQ_READY(wr_rdy), .WR_REQ_CH(wr_ch), .WR_REQ_ADDR(wr_addr),
    .WR_DONE_VALID(wd_v), .WR_DONE_CH(wd_ch),
    .RD_CMD_VALID(rd_v), .RD_CMD_READY(rd_rdy), .RD_CMD_CH(rd_ch), .RD_CMD_ADDR(rd_addr),
    .RD_DONE_VALID(rdn_v), .RD_DONE_CH(rdn_ch),
    .FILL(fill), .FULL(full), .EMPTY(empty), .WM_IRQ(irq), .WM_CLEAR(wmclr), .PROTO_ERR(perr)
  );

  function automatic logic [15:0] fill_of(input int ch);
    return fill[ch*16 +: 16];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int ch);
    wr_v = 1'b1;
    wr_ch = ch[1:0];
    tick;
    wr_v = 1'b0;
  endtask

  task automatic wdone(input int ch);
    wd_v = 1'b1;
    wd_ch = ch[1:0];
    tick;
    wd_v = 1'b0;
  endtask

  task automatic rdone(input int ch);
    rdn_v = 1'b1;
    rdn_ch = ch[1:0];
    tick;
    rdn_v = 1'b0;
  endtask

  task automatic chk_cmd(input string name, input logic [1:0] ch, input logic [31:0] addr);
    chk({name, "_valid"}, 64'(rd_v), 64'd1);
    chk({name, "_ch"}, 64'(rd_ch), 64'(ch));
    chk({name, "_addr"}, 64'(rd_addr), 64'(addr));
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0000, 16'd0, 1'b0, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0400, 16'd0, 1'b0, 1'b0, 32'h0};
    tv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0800, 16'd0, 1'b0, 1'b0, 32'h0};
    tv[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0C00, 16'd0, 1'b1, 1'b0, 32'h0};
    tv[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 16'd0, 1'b1, 1'b0, 32'h0};
    tv[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 16'd1, 1'b1, 1'b0, 32'h0};
    tv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 16'd1, 1'b1, 1'b1, 32'h1000_0000};
    tv[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 16'd0, 1'b0, 1'b0, 32'h0};
    tv[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0000, 16'd0, 1'b1, 1'b0, 32'h0};
    rst = 1'b1;
    base = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    ring = {16'd4, 16'd4, 16'd4, 16'd4};
    wmk = {16'd3, 16'd0, 16'd0, 16'd0};
    sclr = '0; wmclr = '0;
    wr_v = 0; wr_ch = 0; wd_v = 0; wd_ch = 0; rd_rdy = 1; rdn_v = 0; rdn_ch = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick;
    chk("rst_rd_valid", 64'(rd_v), 64'd0);
    chk("rst_fill", fill, 64'd0);
    chk("rst_empty", 64'(empty), 64'hF);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_proto", 64'(perr), 64'd0);

    for (int i = 0; i < 9; i++) begin
      wr_v = tv[i].wv; wr_ch = 0;
      wd_v = tv[i].dv; wd_ch = 0;
      rdn_v = tv[i].rv; rdn_ch = 0;
      rd_rdy = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_wr_ready", i), 64'(wr_rdy), 64'(tv[i].exp_rdy));
      chk($sformatf("v%0d_wr_addr", i), 64'(wr_addr), 64'(tv[i].exp_addr));
      tick;
      chk($sformatf("v%0d_fill0", i), 64'(fill_of(0)), 64'(tv[i].exp_fill));
      chk($sformatf("v%0d_full0", i), 64'(full[0]), 64'(tv[i].exp_full));
      chk($sformatf("v%0d_rd_valid", i), 64'(rd_v), 64'(tv[i].exp_valid));
      if (tv[i].exp_valid) chk($sformatf("v%0d_rd_addr", i), 64'(rd_addr), 64'(tv[i].exp_cmd));
    end
    wr_v = 0; wd_v = 0; rdn_v = 0; rd_rdy = 1;

    sclr = 4'b0001; wd_v = 1'b1; wd_ch = 0;
    tick;
    sclr = '0; wd_v = 1'b0; wr_ch = 0;
    #1;
    chk("clr_fill0", 64'(fill_of(0)), 64'd0);
    chk("clr_full0", 64'(full[0]), 64'd0);
    chk("clr_empty0", 64'(empty[0]), 64'd1);
    chk("clr_wr_ready", 64'(wr_rdy), 64'd1);
    chk("clr_wr_addr", 64'(wr_addr), 64'h1000_0000);
    chk("clr_proto", 64'(perr), 64'd0);

    alloc(1); alloc(2); alloc(3);
    wdone(1);
    chk("rr_valid_lat", 64'(rd_v), 64'd0);
    wdone(2);
    chk_cmd("rr_first", 2'd1, 32'h2000_0000);
    wdone(3);
    chk_cmd("rr_second", 2'd2, 32'h3000_0000);
    tick;
    chk_cmd("rr_third", 2'd3, 32'h4000_0000);
    tick;
    chk("rr_idle", 64'(rd_v), 64'd0);
    rdone(1); rdone(2); rdone(3);
    chk("rr_fill_zero", fill, 64'd0);

    rd_rdy = 1'b0;
    alloc(2); wdone(2); alloc(1);
    chk_cmd("hold_load", 2'd2, 32'h3000_0400);
    wdone(1); alloc(3); wdone(3);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_cmd($sformatf("hold%0d", i), 2'd2, 32'h3000_0400);
      chk($sformatf("hold%0d_fill2", i), 64'(fill_of(2)), 64'd1);
    end
    rd_rdy = 1'b1;
    tick;
    chk_cmd("rel_first", 2'd3, 32'h4000_0400);
    tick;
    chk_cmd("rel_second", 2'd1, 32'h2000_0400);
    tick;
    chk("rel_idle", 64'(rd_v), 64'd0);
    rdone(2); rdone(3); rdone(1);

    alloc(3); alloc(3); alloc(3);
    wdone(3); wdone(3);
    chk("wm_below", 64'(irq[3]), 64'd0);
    wdone(3);
    chk("wm_set", 64'(irq[3]), 64'd1);
    chk("wm_fill3", 64'(fill_of(3)), 64'd3);
    wmclr = 4'b1000;
    tick;
    wmclr = '0;
    chk("wm_cleared", 64'(irq[3]), 64'd0);
    tick;
    chk("wm_no_reset", 64'(irq[3]), 64'd0);
    rdone(3);
    chk("wm_fall_fill", 64'(fill_of(3)), 64'd2);
    chk("wm_fall_irq", 64'(irq[3]), 64'd0);
    alloc(3); wdone(3);
    chk("wm_reset", 64'(irq[3]), 64'd1);
    tick; tick;

    chk("pre_proto", 64'(perr), 64'd0);
    rd_rdy = 1'b0;
    alloc(1); wdone(1); alloc(2); wdone(2);
    rdone(2);
    chk("proto_set", 64'(perr), 64'd1);
    chk("proto_fill2", 64'(fill_of(2)), 64'd1);
    chk_cmd("proto_cmd", 2'd1, 32'h2000_0800);

    #3 rst = 1'b1;
    #1;
    chk("arst_rd_valid", 64'(rd_v), 64'd0);
    chk("arst_fill", fill, 64'd0);
    chk("arst_irq", 64'(irq), 64'h0);
    chk("arst_proto", 64'(perr), 64'd0);
    chk("arst_empty", 64'(empty), 64'hF);
    @(negedge clk) rst = 1'b0;
    tick;

    ring[63:48] = 16'd0;
    wr_ch = 2'd3;
    #1;
    chk("dis_ready", 64'(wr_rdy), 64'd0);
    chk("dis_full", 64'(full[3]), 64'd0);
    wr_ch = 2'd2;
    #1;
    chk("en_ready", 64'(wr_rdy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
